// File: rtl/chess_clock_pkg.sv
// Shared constants and digit-position map for the chess clock display.
package chess_clock_pkg;

  localparam int unsigned MIN_MSB     = 9;
  localparam int unsigned TENS_MSB    = 6;
  localparam int unsigned UNITS_MSB   = 3;
  localparam int unsigned DIGIT_COUNT = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    FieldMin,
    FieldTens,
    FieldUnits,
    FieldBlank
  } field_e;

  typedef struct packed {
    logic   white;
    field_e field;
  } digit_sel_t;

  // idx 7..5 carry white M.SS, 2..0 black M.SS, 4..3 are the gap.
  function automatic digit_sel_t digit_map(input logic [2:0] idx);
    digit_sel_t sel;
    sel.white = idx[2] & (idx[1] | idx[0]);
    case (idx)
      3'd7, 3'd2: sel.field = FieldMin;
      3'd6, 3'd1: sel.field = FieldTens;
      3'd5, 3'd0: sel.field = FieldUnits;
      default:    sel.field = FieldBlank;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-low 7-segment decoder; invalid or out-of-range values show a dash.
module seg7_decode
  import chess_clock_pkg::*;
(
  input  logic [3:0] value,
  input  logic       valid,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (valid) begin
      case (value)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/chess_clock_display.sv
// Multiplexed 8-digit display of both chess clock countdowns with side flashing.
module chess_clock_display
  import chess_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1_000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] countdownWhite,
  input  logic [9:0] countdownBlack,
  input  logic       turn,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IDX_W     = $clog2(DIGIT_COUNT);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [IDX_W-1:0]   idx;
  logic               hidden;
  logic [9:0]         snap_white, snap_black;
  logic               scan_tick, blink_tick;

  assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      blink_cnt  <= '0;
      idx        <= '0;
      hidden     <= 1'b0;
      snap_white <= 10'd0;
      snap_black <= 10'd0;
    end else begin
      scan_cnt  <= scan_tick ? '0 : scan_cnt + 1'b1;
      blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
      if (blink_tick) hidden <= ~hidden;
      if (scan_tick) begin
        idx <= idx + 1'b1;
        // Latch at the frame boundary so a frame never mixes two input values.
        if (idx == IDX_W'(DIGIT_COUNT - 1)) begin
          snap_white <= countdownWhite;
          snap_black <= countdownBlack;
        end
      end
    end
  end

  digit_sel_t sel;
  logic [9:0] side;
  logic [3:0] dec_value;
  logic       dec_valid;
  logic [6:0] dec_seg;
  logic       flash_white, flash_black, blank;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  seg7_decode u_decode (
    .value (dec_value),
    .valid (dec_valid),
    .seg   (dec_seg)
  );

  always_comb begin
    sel       = digit_map(idx);
    side      = sel.white ? snap_white : snap_black;
    dec_value = 4'd0;
    dec_valid = 1'b0;
    case (sel.field)
      FieldMin: begin
        dec_value = {1'b0, side[MIN_MSB -: 3]};
        dec_valid = 1'b1;
      end
      FieldTens: begin
        dec_value = {1'b0, side[TENS_MSB -: 3]};
        dec_valid = (side[TENS_MSB -: 3] <= 3'd5);
      end
      FieldUnits: begin
        dec_value = side[UNITS_MSB -: 4];
        dec_valid = (side[UNITS_MSB -: 4] <= 4'd9);
      end
      default: begin
        dec_value = 4'd0;
        dec_valid = 1'b0;
      end
    endcase

    // A timed-out side always flashes; otherwise the side to move does.
    flash_white = (snap_white == 10'd0) || !turn;
    flash_black = (snap_black == 10'd0) || turn;
    blank = (sel.field == FieldBlank) ||
            (hidden && (sel.white ? flash_white : flash_black));

    an_d  = blank ? 8'hFF : ~(8'b1 << idx);
    seg_d = blank ? SEG_BLANK : dec_seg;
    dp_d  = blank ? 1'b1 : (sel.field != FieldMin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (scan_tick) begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_chess_clock_display.sv
// Scoreboard bench: stimulus queues expected digit outputs, a monitor checks each scan slot.
module tb_chess_clock_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] white, black;
  logic       turn;
  logic [7:0] an, an_s;
  logic [6:0] seg, seg_s;
  logic       dp, dp_s;

  // Primary instance: scan every 4 clk, phase toggles every 16 clk.
  chess_clock_display #(.CLK_HZ(64), .SCAN_HZ(16), .BLINK_HZ(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .countdownWhite (white),
    .countdownBlack (black),
    .turn           (turn),
    .an             (an),
    .seg            (seg),
    .dp             (dp)
  );

  // Slower blink so whole frames alternate visible/hidden.
  chess_clock_display #(.CLK_HZ(64), .SCAN_HZ(16), .BLINK_HZ(1)) dut_slow (
    .clk            (clk),
    .rst            (rst),
    .countdownWhite (white),
    .countdownBlack (black),
    .turn           (turn),
    .an             (an_s),
    .seg            (seg_s),
    .dp             (dp_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  disp_t      q_main[$];
  disp_t      q_slow[$];
  int         checks = 0;
  int         errors = 0;
  bit         done = 1'b0;
  int         slot = 0;
  logic [9:0] m_w = 10'd0;
  logic [9:0] m_b = 10'd0;
  logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] exp_dec(input logic [3:0] v, input bit ok);
    if (ok && v <= 4'd9) return dec_tab[v];
    return 7'h3F;
  endfunction

  function automatic disp_t expect_disp(input int idx, input bit hid, input logic [9:0] w,
                                        input logic [9:0] b, input logic t);
    disp_t      d;
    logic [9:0] s;
    bit         is_white, flash;
    int         pos;
    d = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
    if (idx == 3 || idx == 4) return d;
    is_white = (idx >= 5);
    s        = is_white ? w : b;
    flash    = is_white ? (w == 10'd0 || t == 1'b0) : (b == 10'd0 || t == 1'b1);
    if (hid && flash) return d;
    d.an[idx] = 1'b0;
    pos = is_white ? idx - 5 : idx;
    case (pos)
      2:       begin d.seg = exp_dec({1'b0, s[9:7]}, 1'b1); d.dp = 1'b0; end
      1:       d.seg = exp_dec({1'b0, s[6:4]}, s[6:4] <= 3'd5);
      default: d.seg = exp_dec(s[3:0], 1'b1);
    endcase
    return d;
  endfunction

  task automatic check_disp(input string name, input disp_t got, input disp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
               name, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
    end
  endtask

  task automatic push_slots(input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      slot++;
      idx = (slot - 1) % 8;
      q_main.push_back(expect_disp(idx, ((slot - 1) / 4) % 2 == 1, m_w, m_b, turn));
      q_slow.push_back(expect_disp(idx, ((slot - 1) / 8) % 2 == 1, m_w, m_b, turn));
      if (idx == 7) begin
        m_w = white;
        m_b = black;
      end
    end
  endtask

  task automatic run_slots(input int n);
    push_slots(n);
    repeat (4 * n) @(negedge clk);
  endtask

  // Called at a negedge; leaves the bench at the negedge that ends slot 8 of the new frame.
  task automatic do_reset();
    disp_t rv;
    rv  = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
    rst = 1'b1;
    #1;
    check_disp("reset_async", '{an: an, seg: seg, dp: dp}, rv);
    @(negedge clk);
    check_disp("reset_hold", '{an: an, seg: seg, dp: dp}, rv);
    rst  = 1'b0;
    slot = 0;
    m_w  = 10'd0;
    m_b  = 10'd0;
    push_slots(8);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_disp($sformatf("pre_tick_%0d", i), '{an: an, seg: seg, dp: dp}, rv);
    end
    repeat (29) @(negedge clk);
  endtask

  // Monitor: one output per scan slot, 4 clk apart after reset release.
  initial begin
    int    cnt;
    int    pops;
    disp_t e;
    cnt  = 0;
    pops = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt % 4 == 0) begin
          @(negedge clk);
          if (!done) begin
            pops++;
            if (q_main.size() == 0 || q_slow.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL underflow_%0d got empty queue expected entry", pops);
            end else begin
              e = q_main.pop_front();
              check_disp($sformatf("main_%0d", pops), '{an: an, seg: seg, dp: dp}, e);
              e = q_slow.pop_front();
              check_disp($sformatf("slow_%0d", pops), '{an: an_s, seg: seg_s, dp: dp_s}, e);
            end
          end
        end
      end
    end
  end

  initial begin
    white = 10'b100_101_1001;  // 4:59
    black = 10'b011_000_0111;  // 3:07
    turn  = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    do_reset();                // frame 1: snapshots still zero, both sides flash
    run_slots(8);              // frame 2: 4:59 / 3:07, black to move
    turn = 1'b0;
    run_slots(8);              // frame 3: white flashes
    black = 10'd0;
    white = 10'b001_111_1100;  // tens 7, units 12
    run_slots(8);              // frame 4: old snapshot still shown
    run_slots(16);             // frames 5-6: black timed out, dashes on white
    turn = 1'b1;
    run_slots(3);
    white = 10'b100_101_1001;  // mid-frame change
    run_slots(5);              // frame 7 keeps the dashes
    run_slots(8);              // frame 8 shows the new white time
    run_slots(6);              // frame 9 up to idx 5
    do_reset();                // async reset while idx 5 is lit
    run_slots(8);
    repeat (2) @(negedge clk);
    done = 1'b1;
    checks++;
    if (q_main.size() != 0 || q_slow.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d entries expected 0/0", q_main.size(), q_slow.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
